// File: rtl/awb_gain_calc.sv
// Auto-white-balance statistics and gain engine: accumulates unclipped per-channel
// sums over a frame, then derives red/blue gains relative to green with a serial divider.
module awb_gain_calc #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_COEF_WIDTH = 10,
  parameter int G_FRAC_WIDTH = 4,
  parameter int G_PIXELS     = 4,
  parameter int G_SUM_WIDTH  = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             frame_start_i,
  input  logic                             frame_end_i,
  input  logic                             data_valid_i,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0] data_red_i,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0] data_green_i,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0] data_blue_i,
  output logic [G_COEF_WIDTH-1:0]          gain_red_o,
  output logic [G_COEF_WIDTH-1:0]          gain_green_o,
  output logic [G_COEF_WIDTH-1:0]          gain_blue_o,
  output logic                             gains_valid_o,
  output logic                             busy_o,
  output logic                             frame_drop_o
);

  localparam int N  = G_SUM_WIDTH + G_FRAC_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [G_COEF_WIDTH-1:0] UNITY = G_COEF_WIDTH'(1) << G_FRAC_WIDTH;
  localparam logic [CW-1:0]           LAST  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [G_SUM_WIDTH-1:0]  acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [G_SUM_WIDTH-1:0]  snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
  logic [G_SUM_WIDTH-1:0]  rem_q, rem_d;
  logic [N-1:0]            quo_q, quo_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [G_COEF_WIDTH-1:0] res_r_q, res_r_d, res_b_q, res_b_d;
  logic [G_COEF_WIDTH-1:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic                    valid_q, valid_d, busy_q, busy_d, drop_q, drop_d;

  logic [G_DATA_WIDTH-1:0] lane_r, lane_g, lane_b;
  logic [G_SUM_WIDTH:0]    beat_r, beat_g, beat_b;
  logic [G_SUM_WIDTH-1:0]  base_r, base_g, base_b;
  logic [G_SUM_WIDTH:0]    sum_r, sum_g, sum_b;
  logic [G_SUM_WIDTH-1:0]  divisor;
  logic [G_SUM_WIDTH:0]    rem_shift;
  logic [G_SUM_WIDTH-1:0]  rem_sub;
  logic                    q_bit;
  logic [N-1:0]            quo_next;
  logic [G_COEF_WIDTH-1:0] div_gain;

  always_comb begin
    lane_r = '0;
    lane_g = '0;
    lane_b = '0;
    beat_r = '0;
    beat_g = '0;
    beat_b = '0;
    for (int unsigned k = 0; k < G_PIXELS; k++) begin
      lane_r = data_red_i[k*G_DATA_WIDTH +: G_DATA_WIDTH];
      lane_g = data_green_i[k*G_DATA_WIDTH +: G_DATA_WIDTH];
      lane_b = data_blue_i[k*G_DATA_WIDTH +: G_DATA_WIDTH];
      if (!((lane_r == '1) || (lane_g == '1) || (lane_b == '1))) begin
        beat_r = beat_r + (G_SUM_WIDTH+1)'(lane_r);
        beat_g = beat_g + (G_SUM_WIDTH+1)'(lane_g);
        beat_b = beat_b + (G_SUM_WIDTH+1)'(lane_b);
      end
    end
    // Clear happens before the add so a beat coinciding with start/end opens the new frame.
    if (frame_start_i || frame_end_i) begin
      base_r = '0;
      base_g = '0;
      base_b = '0;
    end else begin
      base_r = acc_r_q;
      base_g = acc_g_q;
      base_b = acc_b_q;
    end
    sum_r = {1'b0, base_r} + (data_valid_i ? beat_r : '0);
    sum_g = {1'b0, base_g} + (data_valid_i ? beat_g : '0);
    sum_b = {1'b0, base_b} + (data_valid_i ? beat_b : '0);
    acc_r_d = sum_r[G_SUM_WIDTH] ? '1 : sum_r[G_SUM_WIDTH-1:0];
    acc_g_d = sum_g[G_SUM_WIDTH] ? '1 : sum_g[G_SUM_WIDTH-1:0];
    acc_b_d = sum_b[G_SUM_WIDTH] ? '1 : sum_b[G_SUM_WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    snap_r_d = snap_r_q;
    snap_g_d = snap_g_q;
    snap_b_d = snap_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_r_d  = res_r_q;
    res_b_d  = res_b_q;
    gain_r_d = gain_r_q;
    gain_b_d = gain_b_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    drop_d   = frame_end_i && (state_q != IDLE);

    // Restoring divide step: remainder always stays below the divisor, so it fits SUM bits.
    divisor   = (state_q == DIV_B) ? snap_b_q : snap_r_q;
    rem_shift = {rem_q, quo_q[N-1]};
    q_bit     = rem_shift >= {1'b0, divisor};
    rem_sub   = rem_shift[G_SUM_WIDTH-1:0] - divisor;
    quo_next  = {quo_q[N-2:0], q_bit};
    if ((divisor == '0) || ((quo_next >> G_COEF_WIDTH) != '0)) begin
      div_gain = '1;
    end else begin
      div_gain = quo_next[G_COEF_WIDTH-1:0];
    end

    case (state_q)
      IDLE: begin
        if (frame_end_i) begin
          snap_r_d = acc_r_q;
          snap_g_d = acc_g_q;
          snap_b_d = acc_b_q;
          if (acc_g_q != '0) begin
            state_d = DIV_R;
            busy_d  = 1'b1;
            quo_d   = {acc_g_q, {G_FRAC_WIDTH{1'b0}}};
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      DIV_R, DIV_B: begin
        rem_d = q_bit ? rem_sub : rem_shift[G_SUM_WIDTH-1:0];
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          rem_d = '0;
          if (state_q == DIV_R) begin
            res_r_d = div_gain;
            quo_d   = {snap_g_q, {G_FRAC_WIDTH{1'b0}}};
            state_d = DIV_B;
          end else begin
            res_b_d = div_gain;
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        gain_r_d = res_r_q;
        gain_b_d = res_b_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_r_q  <= '0;
      acc_g_q  <= '0;
      acc_b_q  <= '0;
      snap_r_q <= '0;
      snap_g_q <= '0;
      snap_b_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      res_r_q  <= UNITY;
      res_b_q  <= UNITY;
      gain_r_q <= UNITY;
      gain_b_q <= UNITY;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_r_q  <= acc_r_d;
      acc_g_q  <= acc_g_d;
      acc_b_q  <= acc_b_d;
      snap_r_q <= snap_r_d;
      snap_g_q <= snap_g_d;
      snap_b_q <= snap_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      res_r_q  <= res_r_d;
      res_b_q  <= res_b_d;
      gain_r_q <= gain_r_d;
      gain_b_q <= gain_b_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign gain_red_o    = gain_r_q;
  assign gain_green_o  = UNITY;
  assign gain_blue_o   = gain_b_q;
  assign gains_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign frame_drop_o  = drop_q;

endmodule

// File: tb/tb_awb_gain_calc.sv
// Scoreboard bench for awb_gain_calc: default instance plus a 12-bit-accumulator
// instance that reaches saturation within a short frame.
module tb_awb_gain_calc;

  localparam int PX   = 4;
  localparam int LAT  = 2 * (32 + 4) + 2;
  localparam int LAT2 = 2 * (12 + 4) + 2;

  typedef struct {
    int unsigned cyc;
    int          r;
    int          b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        fs = 1'b0, fe = 1'b0, dv = 1'b0;
  logic [31:0] dr = '0, dg = '0, db = '0;
  logic [9:0]  gr, gg, gb;
  logic        gv, busy, drop;

  logic        fs2 = 1'b0, fe2 = 1'b0, dv2 = 1'b0;
  logic [31:0] dr2 = '0, dg2 = '0, db2 = '0;
  logic [9:0]  gr2, gg2, gb2;
  logic        gv2, busy2, drop2;

  always #5 clk = ~clk;

  awb_gain_calc dut (
    .clk_i(clk), .rst_i(rst_i), .frame_start_i(fs), .frame_end_i(fe), .data_valid_i(dv),
    .data_red_i(dr), .data_green_i(dg), .data_blue_i(db),
    .gain_red_o(gr), .gain_green_o(gg), .gain_blue_o(gb),
    .gains_valid_o(gv), .busy_o(busy), .frame_drop_o(drop)
  );

  awb_gain_calc #(.G_SUM_WIDTH(12)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .frame_start_i(fs2), .frame_end_i(fe2), .data_valid_i(dv2),
    .data_red_i(dr2), .data_green_i(dg2), .data_blue_i(db2),
    .gain_red_o(gr2), .gain_green_o(gg2), .gain_blue_o(gb2),
    .gains_valid_o(gv2), .busy_o(busy2), .frame_drop_o(drop2)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  int unsigned drop_q[$];

  longint      sum_r = 0, sum_g = 0, sum_b = 0;
  longint      sum2_r = 0, sum2_g = 0, sum2_b = 0;
  int unsigned busy_lo = 1, busy_hi = 0;
  int unsigned busy2_lo = 1, busy2_hi = 0;
  int          cur_r = 16, cur_b = 16, cur2_r = 16, cur2_b = 16;

  function automatic void check(string name, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic longint sat(longint v, int sw);
    longint mx;
    mx = (longint'(1) << sw) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Gain = green*16/channel, truncated, capped at 1023; a zero channel gives 1023.
  function automatic int ref_gain(longint g, longint d);
    longint q;
    if (d == 0) return 1023;
    q = (g * 16) / d;
    return (q > 1023) ? 1023 : int'(q);
  endfunction

  task automatic beat_sum(input logic [31:0] r, g, b, output longint ar, ag, ab);
    logic [7:0] lr, lg, lb;
    ar = 0; ag = 0; ab = 0;
    for (int k = 0; k < PX; k++) begin
      lr = r[k*8 +: 8];
      lg = g[k*8 +: 8];
      lb = b[k*8 +: 8];
      if (lr != 8'hFF && lg != 8'hFF && lb != 8'hFF) begin
        ar += longint'(lr);
        ag += longint'(lg);
        ab += longint'(lb);
      end
    end
  endtask

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic logic [31:0] rnd_px(input int clip_pct);
    logic [31:0] w;
    for (int k = 0; k < PX; k++)
      w[k*8 +: 8] = ($urandom_range(99) < clip_pct) ? 8'hFF : 8'($urandom_range(254));
    return w;
  endfunction

  // Called #1 after a rising edge; inputs are sampled by the next edge.
  task automatic drive(input bit f_s, f_e, v, input logic [31:0] r, g, b);
    longint ar, ag, ab;
    exp_t   e;
    fs = f_s; fe = f_e; dv = v; dr = r; dg = g; db = b;
    if (f_e) begin
      if (cyc >= busy_lo && cyc <= busy_hi) begin
        drop_q.push_back(cyc + 1);
      end else if (sat(sum_g, 32) != 0) begin
        e.cyc = cyc + LAT;
        e.r   = ref_gain(sat(sum_g, 32), sat(sum_r, 32));
        e.b   = ref_gain(sat(sum_g, 32), sat(sum_b, 32));
        exp_q.push_back(e);
        busy_lo = cyc + 1;
        busy_hi = cyc + LAT - 1;
      end
      sum_r = 0; sum_g = 0; sum_b = 0;
    end
    if (f_s) begin
      sum_r = 0; sum_g = 0; sum_b = 0;
    end
    if (v) begin
      beat_sum(r, g, b, ar, ag, ab);
      sum_r += ar; sum_g += ag; sum_b += ab;
    end
    @(posedge clk); #1;
    fs = 1'b0; fe = 1'b0; dv = 1'b0;
  endtask

  task automatic drive2(input bit f_s, f_e, v, input logic [31:0] r, g, b);
    longint ar, ag, ab;
    exp_t   e;
    fs2 = f_s; fe2 = f_e; dv2 = v; dr2 = r; dg2 = g; db2 = b;
    if (f_e) begin
      if (sat(sum2_g, 12) != 0) begin
        e.cyc = cyc + LAT2;
        e.r   = ref_gain(sat(sum2_g, 12), sat(sum2_r, 12));
        e.b   = ref_gain(sat(sum2_g, 12), sat(sum2_b, 12));
        exp2_q.push_back(e);
        busy2_lo = cyc + 1;
        busy2_hi = cyc + LAT2 - 1;
      end
      sum2_r = 0; sum2_g = 0; sum2_b = 0;
    end
    if (f_s) begin
      sum2_r = 0; sum2_g = 0; sum2_b = 0;
    end
    if (v) begin
      beat_sum(r, g, b, ar, ag, ab);
      sum2_r += ar; sum2_g += ag; sum2_b += ab;
    end
    @(posedge clk); #1;
    fs2 = 1'b0; fe2 = 1'b0; dv2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, '0, '0);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    busy_hi = cyc;
    busy2_hi = cyc;
    sum_r = 0; sum_g = 0; sum_b = 0;
    sum2_r = 0; sum2_g = 0; sum2_b = 0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents gains or a drop pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      cur_r = 16; cur_b = 16;
      exp_q.delete();
      drop_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("gains_valid_timeout", 0, 1);
      end
      if (gv) begin
        if (exp_q.size() == 0) begin
          check("gains_valid_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("gains_valid_cycle", cyc, e.cyc);
          check("gain_red", gr, e.r);
          check("gain_blue", gb, e.b);
          cur_r = e.r; cur_b = e.b;
        end
      end else begin
        check("gain_red_hold", gr, cur_r);
        check("gain_blue_hold", gb, cur_b);
      end
      check("gain_green", gg, 16);
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (drop_q.size() > 0 && drop_q[0] < cyc) begin
        void'(drop_q.pop_front());
        check("frame_drop_timeout", 0, 1);
      end
      if (drop) begin
        if (drop_q.size() == 0) check("frame_drop_unexpected", 1, 0);
        else check("frame_drop_cycle", cyc, drop_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      cur2_r = 16; cur2_b = 16;
      exp2_q.delete();
    end else begin
      if (exp2_q.size() > 0 && exp2_q[0].cyc < cyc) begin
        e = exp2_q.pop_front();
        check("sat_gains_valid_timeout", 0, 1);
      end
      if (gv2) begin
        if (exp2_q.size() == 0) begin
          check("sat_gains_valid_unexpected", 1, 0);
        end else begin
          e = exp2_q.pop_front();
          check("sat_gains_valid_cycle", cyc, e.cyc);
          check("sat_gain_red", gr2, e.r);
          check("sat_gain_blue", gb2, e.b);
          cur2_r = e.r; cur2_b = e.b;
        end
      end else if (gr2 != 10'(cur2_r) || gb2 != 10'(cur2_b)) begin
        check("sat_gain_hold", {gr2, gb2}, {10'(cur2_r), 10'(cur2_b)});
      end
      if (gg2 != 10'd16 || drop2 || busy2 != (cyc >= busy2_lo && cyc <= busy2_hi))
        check("sat_status", {gg2, drop2, busy2}, {10'd16, 1'b0, (cyc >= busy2_lo && cyc <= busy2_hi)});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, g, b;
    int          n;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(3);

    // Gray frame: all gains unity.
    drive(1, 0, 1, rep(8'd100), rep(8'd100), rep(8'd100));
    repeat (15) drive(0, 0, 1, rep(8'd100), rep(8'd100), rep(8'd100));
    drive(0, 1, 0, '0, '0, '0);
    idle(80);

    // R=50, G=100, B=200: red 32, blue 8.
    drive(1, 0, 1, rep(8'd50), rep(8'd100), rep(8'd200));
    repeat (15) drive(0, 0, 1, rep(8'd50), rep(8'd100), rep(8'd200));
    drive(0, 1, 0, '0, '0, '0);
    idle(80);

    // Red zero on included lanes; lane 2 clipped through green every beat.
    for (int i = 0; i < 16; i++) begin
      r = '0;
      r[23:16] = 8'($urandom_range(254, 1));
      g = rep(8'd100);
      g[23:16] = 8'hFF;
      b = rnd_px(0);
      drive(i == 0, 0, 1, r, g, b);
    end
    drive(0, 1, 0, '0, '0, '0);
    idle(80);

    // Black frame: no update, no busy.
    drive(1, 0, 1, '0, '0, '0);
    repeat (7) drive(0, 0, 1, '0, '0, '0);
    drive(0, 1, 0, '0, '0, '0);
    idle(20);

    // Random frames with occasional clipped lanes and gaps.
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(20, 4);
      drive(1, 0, 1, rnd_px(10), rnd_px(10), rnd_px(10));
      repeat (n) drive(0, 0, $urandom_range(3) != 0, rnd_px(10), rnd_px(10), rnd_px(10));
      drive(0, 1, 0, '0, '0, '0);
      idle(76);
    end

    // Frame end + frame start together while idle, next frame accumulates during divide.
    drive(1, 0, 1, rnd_px(5), rnd_px(5), rnd_px(5));
    repeat (10) drive(0, 0, 1, rnd_px(5), rnd_px(5), rnd_px(5));
    drive(1, 1, 1, rnd_px(5), rnd_px(5), rnd_px(5));
    repeat (75) drive(0, 0, $urandom_range(1) != 0, rnd_px(5), rnd_px(5), rnd_px(5));
    drive(0, 1, 0, '0, '0, '0);
    idle(80);

    // Second frame end 10 cycles into the divide: dropped, start beat goes to new frame.
    drive(1, 0, 1, rnd_px(0), rnd_px(0), rnd_px(0));
    repeat (8) drive(0, 0, 1, rnd_px(0), rnd_px(0), rnd_px(0));
    drive(0, 1, 0, '0, '0, '0);
    repeat (9) drive(0, 0, 1, rnd_px(0), rnd_px(0), rnd_px(0));
    drive(1, 1, 1, rep(8'd10), rep(8'd40), rep(8'd20));
    repeat (70) drive(0, 0, 0, '0, '0, '0);
    drive(0, 1, 0, '0, '0, '0);
    idle(80);

    // Reset during the 20th cycle of the red divide aborts the result.
    drive(1, 0, 1, rep(8'd30), rep(8'd90), rep(8'd60));
    repeat (5) drive(0, 0, 1, rep(8'd30), rep(8'd90), rep(8'd60));
    drive(0, 1, 0, '0, '0, '0);
    idle(19);
    pulse_reset();
    idle(90);

    // Recovery after reset.
    drive(1, 0, 1, rep(8'd60), rep(8'd90), rep(8'd30));
    repeat (5) drive(0, 0, 1, rep(8'd60), rep(8'd90), rep(8'd30));
    drive(0, 1, 0, '0, '0, '0);
    idle(80);

    // 12-bit accumulators: green and blue saturate at 4095 instead of wrapping.
    drive2(1, 0, 1, rep(8'd100), rep(8'd200), rep(8'd200));
    repeat (7) drive2(0, 0, 1, rep(8'd100), rep(8'd200), rep(8'd200));
    drive2(0, 1, 0, '0, '0, '0);
    repeat (40) drive2(0, 0, 0, '0, '0, '0);
    drive2(1, 0, 1, rnd_px(0), rnd_px(0), rnd_px(0));
    repeat (9) drive2(0, 0, 1, rnd_px(0), rnd_px(0), rnd_px(0));
    drive2(0, 1, 0, '0, '0, '0);
    repeat (40) drive2(0, 0, 0, '0, '0, '0);

    idle(5);
    check("pending_gains", exp_q.size(), 0);
    check("pending_drops", drop_q.size(), 0);
    check("pending_sat_gains", exp2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
